codec_sample_capture: RTL and testbench
=======================================

// Module: codec_sample_capture
// PURPOSE
//  Receive-side counterpart of the playback path: captures ADC samples from the
//  adau1761_codec on each new_frame, optionally decimates them, and buffers them in
//  a FIFO. The FIFO output is first-word-fall-through (FWFT), so the head sample is
//  visible without a read. Downstream consumers (recorder, visualiser) drain it.
//  Sits beside codec_conditioner at the codec boundary and shares the same raw new_frame.
// PARAMETERS
//  ADDR_W    4   FIFO address width; depth = 2**ADDR_W entries of 16 bits
//  DECIMATE  1   keep 1 of every DECIMATE accepted frames; legal range 1..255
// PORTS
//  clk             in   1        system clock
//  reset           in   1        synchronous, active-high; pure top-level reset
//  new_frame       in   1        raw codec frame strobe (level; may stay high >1 cycle)
//  adc_sample_in   in   16       signed ADC sample; valid while new_frame is high
//  capture_en      in   1        1 = accept frames; 0 = ignore frames, clear decimation count
//  rd_en           in   1        pop the head entry; ignored when sample_valid=0
//  clear_overflow  in   1        clears the sticky overflow flag
//  peak_clear      in   1        clears peak_level (used only with the macro)
//  sample_out      out  16       FIFO head; forced to 0 when the FIFO is empty
//  sample_valid    out  1        FIFO not empty
//  fifo_count      out  ADDR_W+1 number of stored entries, 0..2**ADDR_W
//  overflow        out  1        sticky flag: a write was dropped because the FIFO was full
//  peak_level      out  16       max |sample| written since the last clear
// BEHAVIOUR
//  - Reset:
//    - all outputs 0; FIFO empty; read/write pointers 0.
//    - decimation counter 0; new_frame delay flop 0.
//  - Frame detect:
//    - nf_d <= new_frame every cycle.
//    - frame_pulse = new_frame & ~nf_d, i.e. exactly one cycle per frame.
//  - Decimation:
//    - On frame_pulse with capture_en=1: if dcnt == DECIMATE-1, take the sample and set
//      dcnt <= 0; otherwise dcnt <= dcnt+1.
//    - With DECIMATE=1, every frame is taken.
//    - capture_en=0 forces dcnt <= 0 and blocks all writes.
//  - Write:
//    - A taken sample is written to the FIFO on the clock edge that ends the frame_pulse cycle.
//    - adc_sample_in is sampled in that same cycle.
//    - Latency: sample_valid rises the cycle after frame_pulse, if the FIFO was empty.
//  - Read (FWFT):
//    - rd_en & sample_valid advances the read pointer at the edge.
//    - The new head, or 0 if the FIFO is now empty, is on sample_out the next cycle.
//  - Full:
//    - A write while full and without a pop is dropped; overflow <= 1.
//    - A write and a pop in the same cycle while full: both happen; fifo_count is
//      unchanged and overflow is not set.
//  - Empty:
//    - rd_en is ignored; fifo_count never underflows.
//    - A write and rd_en in the same cycle while empty: only the write happens.
//  - Pointers: ADDR_W-bit, wrap modulo depth; fifo_count = wr_total - rd_total,
//    kept in ADDR_W+1 bits.
//  - Overflow flag:
//    - clear_overflow has priority over a set in the same cycle.
//    - The flag is cleared on that edge even if a drop also occurs in that cycle.
//  - Mid-operation: reset discards FIFO contents and any partially counted decimation.
//  - new_frame held high for several cycles produces one frame only. A new frame needs
//    new_frame to go low and then high again.
// CONFIGURATION
//  PEAK_METER_EN defined:
//    - On every accepted write, abs = |adc_sample_in|; 16'h8000 saturates to 16'h7FFF.
//    - If abs > peak_level, then peak_level <= abs.
//    - peak_clear sets peak_level <= 0. It has priority over an update in the same cycle.
//    - Dropped (overflow) samples do not update the peak.
//  PEAK_METER_EN undefined: peak_level is tied to 16'h0000; peak_clear is ignored;
//    no comparator logic.
// TESTING
//  1. Reset, DECIMATE=1, capture_en=1, frames carrying 0x1234 then 0xFEDC, no rd_en ->
//     sample_valid=1 one cycle after the first pulse; sample_out=0x1234; fifo_count=2.
//  2. Hold new_frame high 5 cycles with one sample -> fifo_count increases by exactly 1.
//  3. ADDR_W=2: 5 frames with no reads -> fifo_count=4, overflow=1, and the drained
//     order is samples 1-4. Then pulse clear_overflow -> overflow=0.
//  4. Full FIFO; frame_pulse and rd_en in the same cycle -> fifo_count stays 4,
//     overflow stays 0, and the head advances.
//  5. DECIMATE=3, 7 frames with values 1..7 -> FIFO holds 3 then 6. Drop capture_en for
//     1 cycle after frame 7, re-enable, send 2 frames (8, 9) -> 9 is not stored yet
//     (counter restarted from 0); a 3rd frame (10) is stored.
//  6. PEAK_METER_EN: write samples 0x0100, 0x8000, 0xFF00 -> peak_level=0x7FFF.
//     Assert peak_clear, then write 0xFF00 -> peak_level=0x0100. Without the macro,
//     peak_level stays 0 throughout.

Source files
------------

// File: rtl/codec_sample_capture_if.sv
// Read-side bundle of codec_sample_capture: FWFT head, occupancy and pop strobe.
// The slave modport is the capture block, the master modport is the downstream consumer.
interface codec_sample_capture_if #(
    parameter int ADDR_W = 4
) ();
    logic              rd_en;
    logic [15:0]       sample_out;
    logic              sample_valid;
    logic [ADDR_W:0]   fifo_count;

    modport master (
        output rd_en,
        input  sample_out,
        input  sample_valid,
        input  fifo_count
    );

    modport slave (
        input  rd_en,
        output sample_out,
        output sample_valid,
        output fifo_count
    );
endinterface

// File: rtl/codec_sample_capture.sv
// Captures codec ADC samples on each new_frame edge, decimates, and buffers them in a FWFT FIFO.
// Optional peak meter on written samples is enabled by defining PEAK_METER_EN.
module codec_sample_capture #(
    parameter int ADDR_W   = 4,
    parameter int DECIMATE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_frame,
    input  logic [15:0] adc_sample_in,
    input  logic        capture_en,
    input  logic        clear_overflow,
    input  logic        peak_clear,
    output logic        overflow,
    output logic [15:0] peak_level,
    codec_sample_capture_if.slave rd_if
);

    localparam int              DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [7:0]      DCNT_LAST  = 8'(DECIMATE - 1);

    logic                nf_d;
    logic                frame_pulse;
    logic [7:0]          dcnt;
    logic [15:0]         mem [DEPTH];
    logic [ADDR_W:0]     wr_total;
    logic [ADDR_W:0]     rd_total;
    logic [ADDR_W:0]     count;
    logic                full;
    logic                empty;
    logic                take;
    logic                do_pop;
    logic                do_write;

    assign frame_pulse = new_frame & ~nf_d;
    assign count       = wr_total - rd_total;
    assign full        = (count == FULL_COUNT);
    assign empty       = (count == '0);
    assign take        = frame_pulse & capture_en & (dcnt == DCNT_LAST);
    assign do_pop      = rd_if.rd_en & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign do_write    = take & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            nf_d     <= 1'b0;
            dcnt     <= '0;
            wr_total <= '0;
            rd_total <= '0;
            overflow <= 1'b0;
        end else begin
            nf_d <= new_frame;
            if (!capture_en) begin
                dcnt <= '0;
            end else if (frame_pulse) begin
                dcnt <= (dcnt == DCNT_LAST) ? 8'd0 : dcnt + 8'd1;
            end
            if (do_write) begin
                wr_total <= wr_total + 1'b1;
            end
            if (do_pop) begin
                rd_total <= rd_total + 1'b1;
            end
            if (clear_overflow) begin
                overflow <= 1'b0;
            end else if (take && full && !do_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            mem[wr_total[ADDR_W-1:0]] <= adc_sample_in;
        end
    end

    assign rd_if.sample_out   = empty ? 16'h0000 : mem[rd_total[ADDR_W-1:0]];
    assign rd_if.sample_valid = ~empty;
    assign rd_if.fifo_count   = count;

`ifdef PEAK_METER_EN
    logic [15:0] abs_sample;

    // Most negative code has no positive twin, so it saturates.
    always_comb begin
        abs_sample = adc_sample_in;
        if (adc_sample_in == 16'h8000) begin
            abs_sample = 16'h7FFF;
        end else if (adc_sample_in[15]) begin
            abs_sample = ~adc_sample_in + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            peak_level <= 16'h0000;
        end else if (peak_clear) begin
            peak_level <= 16'h0000;
        end else if (do_write && (abs_sample > peak_level)) begin
            peak_level <= abs_sample;
        end
    end
`else
    logic peak_clear_unused;

    assign peak_clear_unused = peak_clear;
    assign peak_level        = 16'h0000;
`endif

endmodule

// File: tb/tb_codec_sample_capture.sv
// Scoreboard bench for codec_sample_capture: a small-FIFO instance (depth 4, no decimation)
// and a decimate-by-3 instance, each checked against queues of expected samples.
module tb_codec_sample_capture;

    logic clk;
    logic reset;

    logic        a_nf, a_cap, a_clr, a_pclr, a_ovf;
    logic [15:0] a_adc, a_peak;
    logic        b_nf, b_cap, b_clr, b_pclr, b_ovf;
    logic [15:0] b_adc, b_peak;

    logic [15:0] qa [$];
    logic [15:0] qb [$];
    logic [15:0] exp_val;
    logic [15:0] exp_peak;
    int          n_cmp;
    int          n_fail;

    codec_sample_capture_if #(.ADDR_W(2)) a_if ();
    codec_sample_capture_if #(.ADDR_W(4)) b_if ();

    codec_sample_capture #(.ADDR_W(2), .DECIMATE(1)) dut_a (
        .clk            (clk),
        .reset          (reset),
        .new_frame      (a_nf),
        .adc_sample_in  (a_adc),
        .capture_en     (a_cap),
        .clear_overflow (a_clr),
        .peak_clear     (a_pclr),
        .overflow       (a_ovf),
        .peak_level     (a_peak),
        .rd_if          (a_if.slave)
    );

    codec_sample_capture #(.ADDR_W(4), .DECIMATE(3)) dut_b (
        .clk            (clk),
        .reset          (reset),
        .new_frame      (b_nf),
        .adc_sample_in  (b_adc),
        .capture_en     (b_cap),
        .clear_overflow (b_clr),
        .peak_clear     (b_pclr),
        .overflow       (b_ovf),
        .peak_level     (b_peak),
        .rd_if          (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // All tasks start and end one time unit after a rising edge.
    task automatic applyStimulus;
        @(posedge clk);
        #1;
    endtask

    task automatic a_frame(input logic [15:0] v, input int hold, input logic rd, input logic clr);
        a_nf = 1'b1;
        a_adc = v;
        a_if.rd_en = rd;
        a_clr = clr;
        applyStimulus();
        a_if.rd_en = 1'b0;
        a_clr = 1'b0;
        for (int i = 1; i < hold; i++) applyStimulus();
        a_nf = 1'b0;
        a_adc = 16'h0000;
        applyStimulus();
    endtask

    task automatic b_frame(input logic [15:0] v);
        b_nf = 1'b1;
        b_adc = v;
        applyStimulus();
        b_nf = 1'b0;
        b_adc = 16'h0000;
        applyStimulus();
    endtask

    task automatic a_pop;
        a_if.rd_en = 1'b1;
        applyStimulus();
        a_if.rd_en = 1'b0;
    endtask

    task automatic b_pop;
        b_if.rd_en = 1'b1;
        applyStimulus();
        b_if.rd_en = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) applyStimulus();
        reset = 1'b0;
        n_cmp++;
        if (a_if.sample_valid !== 1'b0 || a_if.sample_out !== 16'h0000 || a_if.fifo_count !== 3'd0 || a_ovf !== 1'b0 || a_peak !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL reset_a: got valid=%b out=%h cnt=%0d ovf=%b peak=%h, expected all zero",
                     a_if.sample_valid, a_if.sample_out, a_if.fifo_count, a_ovf, a_peak);
        end
        n_cmp++;
        if (b_if.sample_valid !== 1'b0 || b_if.fifo_count !== 5'd0 || b_ovf !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_b: got valid=%b cnt=%0d ovf=%b, expected all zero",
                     b_if.sample_valid, b_if.fifo_count, b_ovf);
        end
    endtask

    task automatic test_basic;
        a_nf = 1'b1;
        a_adc = 16'h1234;
        n_cmp++;
        if (a_if.sample_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL valid_during_pulse: got %b expected 0", a_if.sample_valid);
        end
        qa.push_back(16'h1234);
        applyStimulus();
        n_cmp++;
        if (a_if.sample_valid !== 1'b1 || a_if.sample_out !== 16'h1234) begin
            n_fail++;
            $display("[TB] FAIL first_latency: got valid=%b out=%h expected valid=1 out=1234",
                     a_if.sample_valid, a_if.sample_out);
        end
        a_nf = 1'b0;
        a_adc = 16'h0000;
        applyStimulus();
        qa.push_back(16'hFEDC);
        a_frame(16'hFEDC, 1, 1'b0, 1'b0);
        n_cmp++;
        if (int'(a_if.fifo_count) !== qa.size() || a_if.sample_out !== qa[0]) begin
            n_fail++;
            $display("[TB] FAIL basic_count: got cnt=%0d out=%h expected cnt=%0d out=%h",
                     a_if.fifo_count, a_if.sample_out, qa.size(), qa[0]);
        end
        while (qa.size() > 0) begin
            exp_val = qa.pop_front();
            n_cmp++;
            if (a_if.sample_valid !== 1'b1 || a_if.sample_out !== exp_val) begin
                n_fail++;
                $display("[TB] FAIL basic_drain: got %h expected %h", a_if.sample_out, exp_val);
            end
            a_pop();
        end
        n_cmp++;
        if (a_if.sample_valid !== 1'b0 || a_if.sample_out !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL basic_empty: got valid=%b out=%h expected 0 0000", a_if.sample_valid, a_if.sample_out);
        end
    endtask

    task automatic test_hold_and_empty;
        qa.push_back(16'h0A5A);
        a_frame(16'h0A5A, 5, 1'b0, 1'b0);
        n_cmp++;
        if (int'(a_if.fifo_count) !== qa.size()) begin
            n_fail++;
            $display("[TB] FAIL held_frame: got cnt=%0d expected %0d", a_if.fifo_count, qa.size());
        end
        exp_val = qa.pop_front();
        n_cmp++;
        if (a_if.sample_out !== exp_val) begin
            n_fail++;
            $display("[TB] FAIL held_value: got %h expected %h", a_if.sample_out, exp_val);
        end
        a_pop();
        a_pop();
        n_cmp++;
        if (a_if.fifo_count !== 3'd0 || a_if.sample_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL empty_read: got cnt=%0d valid=%b expected 0 0", a_if.fifo_count, a_if.sample_valid);
        end
        qa.push_back(16'h0777);
        a_frame(16'h0777, 1, 1'b1, 1'b0);
        n_cmp++;
        if (int'(a_if.fifo_count) !== qa.size() || a_if.sample_out !== qa[0]) begin
            n_fail++;
            $display("[TB] FAIL empty_write_read: got cnt=%0d out=%h expected cnt=%0d out=%h",
                     a_if.fifo_count, a_if.sample_out, qa.size(), qa[0]);
        end
        while (qa.size() > 0) begin
            exp_val = qa.pop_front();
            a_pop();
        end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) qa.push_back(16'(i * 'h0111));
            a_frame(16'(i * 'h0111), 1, 1'b0, 1'b0);
        end
        n_cmp++;
        if (a_if.fifo_count !== 3'd4 || a_ovf !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL overflow_set: got cnt=%0d ovf=%b expected 4 1", a_if.fifo_count, a_ovf);
        end
        a_frame(16'h0666, 1, 1'b0, 1'b1);
        n_cmp++;
        if (a_ovf !== 1'b0 || a_if.fifo_count !== 3'd4) begin
            n_fail++;
            $display("[TB] FAIL clear_priority: got ovf=%b cnt=%0d expected 0 4", a_ovf, a_if.fifo_count);
        end
        a_frame(16'h0667, 1, 1'b0, 1'b0);
        a_clr = 1'b1;
        applyStimulus();
        a_clr = 1'b0;
        n_cmp++;
        if (a_ovf !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL overflow_clear: got %b expected 0", a_ovf);
        end
        while (qa.size() > 0) begin
            exp_val = qa.pop_front();
            n_cmp++;
            if (a_if.sample_valid !== 1'b1 || a_if.sample_out !== exp_val) begin
                n_fail++;
                $display("[TB] FAIL overflow_order: got %h expected %h", a_if.sample_out, exp_val);
            end
            a_pop();
        end
    endtask

    task automatic test_full_pop;
        for (int i = 0; i < 4; i++) begin
            qa.push_back(16'h0A00 + 16'(i));
            a_frame(16'h0A00 + 16'(i), 1, 1'b0, 1'b0);
        end
        exp_val = qa.pop_front();
        qa.push_back(16'h0BBB);
        a_frame(16'h0BBB, 1, 1'b1, 1'b0);
        n_cmp++;
        if (a_if.fifo_count !== 3'd4 || a_ovf !== 1'b0 || a_if.sample_out !== qa[0]) begin
            n_fail++;
            $display("[TB] FAIL full_write_pop: got cnt=%0d ovf=%b out=%h expected 4 0 %h",
                     a_if.fifo_count, a_ovf, a_if.sample_out, qa[0]);
        end
        while (qa.size() > 0) begin
            exp_val = qa.pop_front();
            n_cmp++;
            if (a_if.sample_valid !== 1'b1 || a_if.sample_out !== exp_val) begin
                n_fail++;
                $display("[TB] FAIL full_pop_drain: got %h expected %h", a_if.sample_out, exp_val);
            end
            a_pop();
        end
    endtask

    task automatic test_peak;
        foreach (qa[i]) qa.delete(i);
        qa.push_back(16'h0100);
        qa.push_back(16'h8000);
        qa.push_back(16'hFF00);
        a_frame(16'h0100, 1, 1'b0, 1'b0);
        a_frame(16'h8000, 1, 1'b0, 1'b0);
        a_frame(16'hFF00, 1, 1'b0, 1'b0);
`ifdef PEAK_METER_EN
        exp_peak = 16'h7FFF;
`else
        exp_peak = 16'h0000;
`endif
        n_cmp++;
        if (a_peak !== exp_peak) begin
            n_fail++;
            $display("[TB] FAIL peak_saturate: got %h expected %h", a_peak, exp_peak);
        end
        a_pclr = 1'b1;
        applyStimulus();
        a_pclr = 1'b0;
        qa.push_back(16'hFF00);
        a_frame(16'hFF00, 1, 1'b1, 1'b0);
        void'(qa.pop_front());
`ifdef PEAK_METER_EN
        exp_peak = 16'h0100;
`endif
        n_cmp++;
        if (a_peak !== exp_peak) begin
            n_fail++;
            $display("[TB] FAIL peak_after_clear: got %h expected %h", a_peak, exp_peak);
        end
        while (qa.size() > 0) begin
            exp_val = qa.pop_front();
            a_pop();
        end
        a_pclr = 1'b1;
        applyStimulus();
        a_pclr = 1'b0;
        for (int i = 0; i < 4; i++) a_frame(16'h0010, 1, 1'b0, 1'b0);
        a_frame(16'h7000, 1, 1'b0, 1'b0);
`ifdef PEAK_METER_EN
        exp_peak = 16'h0010;
`endif
        n_cmp++;
        if (a_peak !== exp_peak || a_ovf !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL peak_dropped: got peak=%h ovf=%b expected %h 1", a_peak, a_ovf, exp_peak);
        end
        a_clr = 1'b1;
        applyStimulus();
        a_clr = 1'b0;
        repeat (4) a_pop();
    endtask

    task automatic test_decimate;
        for (int i = 1; i <= 7; i++) begin
            if (i % 3 == 0) qb.push_back(16'(i));
            b_frame(16'(i));
        end
        n_cmp++;
        if (int'(b_if.fifo_count) !== qb.size() || b_if.sample_out !== qb[0]) begin
            n_fail++;
            $display("[TB] FAIL decimate_3: got cnt=%0d out=%h expected cnt=%0d out=%h",
                     b_if.fifo_count, b_if.sample_out, qb.size(), qb[0]);
        end
        b_cap = 1'b0;
        applyStimulus();
        b_cap = 1'b1;
        b_frame(16'd8);
        b_frame(16'd9);
        n_cmp++;
        if (int'(b_if.fifo_count) !== qb.size()) begin
            n_fail++;
            $display("[TB] FAIL decimate_restart: got cnt=%0d expected %0d", b_if.fifo_count, qb.size());
        end
        qb.push_back(16'd10);
        b_frame(16'd10);
        while (qb.size() > 0) begin
            exp_val = qb.pop_front();
            n_cmp++;
            if (b_if.sample_valid !== 1'b1 || b_if.sample_out !== exp_val) begin
                n_fail++;
                $display("[TB] FAIL decimate_drain: got %h expected %h", b_if.sample_out, exp_val);
            end
            b_pop();
        end
    endtask

    task automatic test_mid_reset;
        a_frame(16'h0321, 1, 1'b0, 1'b0);
        a_frame(16'h0322, 1, 1'b0, 1'b0);
        b_frame(16'd21);
        b_frame(16'd22);
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        n_cmp++;
        if (a_if.fifo_count !== 3'd0 || a_if.sample_valid !== 1'b0 || a_if.sample_out !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_fifo: got cnt=%0d valid=%b out=%h expected 0 0 0000",
                     a_if.fifo_count, a_if.sample_valid, a_if.sample_out);
        end
        b_frame(16'd23);
        b_frame(16'd24);
        n_cmp++;
        if (b_if.fifo_count !== 5'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_dcnt: got cnt=%0d expected 0", b_if.fifo_count);
        end
        qb.push_back(16'd25);
        b_frame(16'd25);
        exp_val = qb.pop_front();
        n_cmp++;
        if (b_if.fifo_count !== 5'd1 || b_if.sample_out !== exp_val) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_take: got cnt=%0d out=%h expected 1 %h", b_if.fifo_count, b_if.sample_out, exp_val);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b1;
        a_nf = 1'b0; a_adc = 16'h0000; a_cap = 1'b1; a_clr = 1'b0; a_pclr = 1'b0;
        b_nf = 1'b0; b_adc = 16'h0000; b_cap = 1'b1; b_clr = 1'b0; b_pclr = 1'b0;
        a_if.rd_en = 1'b0;
        b_if.rd_en = 1'b0;
        exp_val = 16'h0000;
        exp_peak = 16'h0000;
        test_reset();
        test_basic();
        test_hold_and_empty();
        test_overflow();
        test_full_pop();
        test_peak();
        test_decimate();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
